// File: rtl/iddmm_var_top.sv
// Word-serial CIOS Montgomery multiplier: R = X*Y*2^(-K*n) mod M with a runtime word count n.
// Operands live in register RAMs; the result streams out one word per cycle, LSW first.
module iddmm_var_top #(
  parameter int unsigned K      = 128,
  parameter int unsigned N      = 32,
  parameter int unsigned ADDR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        wr_ena,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [K-1:0]      wr_x,
  input  logic [K-1:0]      wr_y,
  input  logic [K-1:0]      wr_m,
  input  logic [K-1:0]      wr_m1,
  input  logic [ADDR_W:0]   cfg_nwords,
  input  logic              task_req,
  output logic              task_ack,
  output logic              task_err,
  output logic              busy,
  output logic              res_valid,
  output logic              res_last,
  output logic [K-1:0]      res_data
);

  localparam int unsigned K2 = 2 * K;
  localparam int unsigned TW = $clog2(N + 2);

  typedef enum logic [3:0] {
    StIdle, StMul, StMtop, StQcalc, StRed, StRtop, StSub, StSel, StOut
  } state_e;

  state_e state_q, state_d;

  logic [K-1:0]      x_mem [N];
  logic [K-1:0]      y_mem [N];
  logic [K-1:0]      m_mem [N];
  logic [K-1:0]      t_q   [N+2];
  logic [K-1:0]      d_q   [N];
  logic [K-1:0]      m1_q, c_q, q_q;
  logic [ADDR_W:0]   n_q;
  logic [ADDR_W-1:0] i_q, j_q;
  logic              borrow_q, sel_q;
  logic              busy_q, ack_q, err_q, res_valid_q, res_last_q;
  logic [K-1:0]      res_data_q;

  logic              busy_d, res_valid_d, res_last_d;
  logic [K-1:0]      res_data_d;
  logic              cfg_ok, accept, reject, j_last, i_last;
  logic [TW-1:0]     tj, tjm1, tn, tn1, tnm1;
  logic [K2-1:0]     mul_sum, red_sum;
  logic [K:0]        top_sum, sub_diff;

  // Operand RAMs are frozen while a task runs so the datapath sees stable operands.
  always_ff @(posedge clk) begin
    if (!busy_q) begin
      if (wr_ena[0]) x_mem[wr_addr] <= wr_x;
      if (wr_ena[1]) y_mem[wr_addr] <= wr_y;
      if (wr_ena[2]) m_mem[wr_addr] <= wr_m;
    end
  end

  always_comb begin
    tj       = TW'(j_q);
    tjm1     = tj - TW'(1);
    tn       = TW'(n_q);
    tn1      = tn + TW'(1);
    tnm1     = tn - TW'(1);
    j_last   = ({1'b0, j_q} == n_q - (ADDR_W+1)'(1));
    i_last   = ({1'b0, i_q} == n_q - (ADDR_W+1)'(1));
    mul_sum  = K2'(t_q[tj]) + K2'(x_mem[j_q]) * K2'(y_mem[i_q]) + K2'(c_q);
    red_sum  = K2'(t_q[tj]) + K2'(q_q) * K2'(m_mem[j_q]) + K2'(c_q);
    top_sum  = (K+1)'(t_q[tn]) + (K+1)'(c_q);
    sub_diff = (K+1)'(t_q[tj]) - (K+1)'(m_mem[j_q]) - (K+1)'(borrow_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StMul;
      StMul:   if (j_last) state_d = StMtop;
      StMtop:  state_d = StQcalc;
      StQcalc: state_d = StRed;
      StRed:   if (j_last) state_d = StRtop;
      StRtop:  state_d = i_last ? StSub : StMul;
      StSub:   if (j_last) state_d = StSel;
      StSel:   state_d = StOut;
      StOut:   if (j_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered, so busy is held through the cycle that shows res_last.
  always_comb begin
    cfg_ok      = (cfg_nwords != '0) && (cfg_nwords <= (ADDR_W+1)'(N));
    accept      = (state_q == StIdle) && !busy_q && task_req && cfg_ok;
    reject      = !busy_q && task_req && !cfg_ok;
    busy_d      = accept ? 1'b1 : (res_last_q ? 1'b0 : busy_q);
    res_valid_d = (state_q == StOut);
    res_last_d  = (state_q == StOut) && j_last;
    res_data_d  = '0;
    if (state_q == StOut) res_data_d = sel_q ? d_q[j_q] : t_q[tj];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      res_data_q  <= '0;
      m1_q        <= '0;
    end else begin
      busy_q      <= busy_d;
      ack_q       <= accept;
      err_q       <= reject;
      res_valid_q <= res_valid_d;
      res_last_q  <= res_last_d;
      res_data_q  <= res_data_d;
      if (!busy_q && wr_ena[2]) m1_q <= wr_m1;
    end
  end

  // Datapath state is fully initialised at accept, so it needs no reset.
  always_ff @(posedge clk) begin
    case (state_q)
      StIdle: begin
        if (accept) begin
          n_q      <= cfg_nwords;
          i_q      <= '0;
          j_q      <= '0;
          c_q      <= '0;
          borrow_q <= 1'b0;
          for (int k = 0; k < N + 2; k++) t_q[k] <= '0;
        end
      end
      StMul: begin
        t_q[tj] <= mul_sum[K-1:0];
        c_q     <= mul_sum[K2-1:K];
        j_q     <= j_last ? '0 : j_q + ADDR_W'(1);
      end
      StMtop: begin
        t_q[tn]  <= top_sum[K-1:0];
        t_q[tn1] <= K'(top_sum[K]);
        c_q      <= '0;
      end
      StQcalc: q_q <= t_q[0] * m1_q;
      StRed: begin
        // Word 0 of T + q*M is zero by construction; only its carry is kept.
        if (j_q != '0) t_q[tjm1] <= red_sum[K-1:0];
        c_q <= red_sum[K2-1:K];
        j_q <= j_last ? '0 : j_q + ADDR_W'(1);
      end
      StRtop: begin
        t_q[tnm1] <= top_sum[K-1:0];
        t_q[tn]   <= t_q[tn1] + K'(top_sum[K]);
        t_q[tn1]  <= '0;
        c_q       <= '0;
        i_q       <= i_q + ADDR_W'(1);
        borrow_q  <= 1'b0;
      end
      StSub: begin
        d_q[j_q] <= sub_diff[K-1:0];
        borrow_q <= sub_diff[K];
        j_q      <= j_last ? '0 : j_q + ADDR_W'(1);
      end
      StSel: sel_q <= (t_q[tn] != '0) || !borrow_q;
      StOut: j_q <= j_last ? '0 : j_q + ADDR_W'(1);
      default: ;
    endcase
  end

  assign task_ack  = ack_q;
  assign task_err  = err_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_last  = res_last_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_iddmm_var_top.sv
// Directed and randomized bench for iddmm_var_top (K=8, N=4) against an arithmetic
// Montgomery model built from repeated modular halving.
module tb_iddmm_var_top;

  localparam int K  = 8;
  localparam int N  = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    wr_ena = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [K-1:0]  wr_x = '0, wr_y = '0, wr_m = '0, wr_m1 = '0;
  logic [AW:0]   cfg_nwords = '0;
  logic          task_req = 1'b0;
  logic          task_ack, task_err, busy, res_valid, res_last;
  logic [K-1:0]  res_data;

  int checks = 0;
  int errors = 0;

  longint unsigned xv, yv, mv;
  logic [7:0]      m1v;
  logic [63:0]     res;
  int              lat;

  iddmm_var_top #(.K(K), .N(N), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_ena     (wr_ena),
    .wr_addr    (wr_addr),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_m       (wr_m),
    .wr_m1      (wr_m1),
    .cfg_nwords (cfg_nwords),
    .task_req   (task_req),
    .task_ack   (task_ack),
    .task_err   (task_err),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_last   (res_last),
    .res_data   (res_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // X*Y*2^(-8n) mod M by halving modulo odd M, one bit at a time.
  function automatic longint unsigned mont(input longint unsigned x, input longint unsigned y,
                                           input longint unsigned m, input int n);
    longint unsigned r;
    r = (x * y) % m;
    for (int b = 0; b < 8 * n; b++) begin
      if (r[0]) r = r + m;
      r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] neg_inv(input longint unsigned m);
    for (int v = 0; v < 256; v++)
      if ((((int'(m[7:0]) * v) + 1) % 256) == 0) return 8'(v);
    return 8'h00;
  endfunction

  task automatic load(input int n);
    for (int j = 0; j < n; j++) begin
      wr_ena  = 3'b111;
      wr_addr = AW'(j);
      wr_x    = 8'(xv >> (8 * j));
      wr_y    = 8'(yv >> (8 * j));
      wr_m    = 8'(mv >> (8 * j));
      wr_m1   = m1v;
      tick();
    end
    wr_ena = '0;
  endtask

  task automatic pick(input int n);
    longint unsigned mask;
    mask = (n == 4) ? 64'hFFFF_FFFF : ((64'd1 << (8 * n)) - 1);
    mv   = ({$urandom, $urandom} & mask) | 64'd1;
    xv   = {$urandom, $urandom} % mv;
    yv   = {$urandom, $urandom} % mv;
    m1v  = neg_inv(mv);
  endtask

  // Starts a task, optionally pokes task_req or an X write mid-run, collects the result.
  task automatic run(input int n, input int poke_cyc, input bit poke_req, input bit poke_wr,
                     output logic [63:0] r, output int l);
    int  cnt;
    int  idx;
    bit  done;
    r = '0; l = -1; idx = 0; done = 0; cnt = 0;
    cfg_nwords = (AW+1)'(n);
    task_req   = 1'b1;
    tick();
    task_req = 1'b0;
    chk("ack_pulse", 64'(task_ack), 64'(1));
    chk("busy_rise", 64'(busy), 64'(1));
    chk("idle_data_zero", 64'(res_data), 64'(0));
    while (!done && cnt < 300) begin
      if (cnt == poke_cyc) begin
        task_req = poke_req;
        if (poke_wr) begin
          wr_ena = 3'b001; wr_addr = '0; wr_x = 8'hFF;
        end
      end
      tick();
      cnt++;
      if (cnt == poke_cyc + 1) begin
        task_req = 1'b0;
        wr_ena   = '0;
        if (poke_req) begin
          chk("busy_req_no_ack", 64'(task_ack), 64'(0));
          chk("busy_req_no_err", 64'(task_err), 64'(0));
        end
      end
      if (res_valid) begin
        if (l < 0) l = cnt;
        r = r | (64'(res_data) << (8 * idx));
        chk("res_last_flag", 64'(res_last), 64'(idx == n - 1));
        idx++;
        if (res_last) done = 1;
      end
    end
    chk("task_done", 64'(done), 64'(1));
    if (done) begin
      tick();
      chk("busy_fall", 64'(busy), 64'(0));
      chk("post_data_zero", 64'(res_data), 64'(0));
    end
  endtask

  initial begin
    int n;
    int vcnt;
    longint unsigned exp_r;

    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ack", 64'(task_ack), 64'(0));
    chk("rst_err", 64'(task_err), 64'(0));
    chk("rst_valid", 64'(res_valid), 64'(0));
    chk("rst_last", 64'(res_last), 64'(0));
    chk("rst_data", 64'(res_data), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // Directed n=1 vectors
    mv = 64'hE5; m1v = 8'h13; xv = 64'h1B; yv = 64'h05;
    load(1);
    run(1, -1, 0, 0, res, lat);
    chk("n1_result", res, 64'h05);
    chk("n1_latency", 64'(lat), 64'(8));
    xv = 64'hE4; yv = 64'hE4;
    load(1);
    run(1, -1, 0, 0, res, lat);
    chk("n1_sub_result", res, 64'h11);

    // Zero operand over four words
    pick(4);
    xv = 0;
    load(4);
    run(4, -1, 0, 0, res, lat);
    chk("n4_zero_result", res, 64'h0);
    chk("n4_latency", 64'(lat), 64'(50));

    // Bad word counts
    cfg_nwords = '0; task_req = 1'b1;
    tick();
    task_req = 1'b0;
    chk("n0_err", 64'(task_err), 64'(1));
    chk("n0_no_ack", 64'(task_ack), 64'(0));
    chk("n0_busy", 64'(busy), 64'(0));
    tick();
    chk("n0_err_pulse", 64'(task_err), 64'(0));
    cfg_nwords = 3'd5; task_req = 1'b1;
    tick();
    task_req = 1'b0;
    chk("n5_err", 64'(task_err), 64'(1));
    chk("n5_no_ack", 64'(task_ack), 64'(0));
    chk("n5_busy", 64'(busy), 64'(0));
    tick();

    // Random operands and lengths
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(1, 4);
      pick(n);
      load(n);
      run(n, -1, 0, 0, res, lat);
      chk("rand_result", res, mont(xv, yv, mv, n));
      chk("rand_latency", 64'(lat), 64'(2 + n * (2 * n + 3) + n));
    end

    // Request while busy, then X write while busy; second run is back-to-back
    n = 3;
    pick(n);
    load(n);
    exp_r = mont(xv, yv, mv, n);
    run(n, 4, 1, 0, res, lat);
    chk("busy_req_result", res, exp_r);
    run(n, 3, 0, 1, res, lat);
    chk("busy_wr_result", res, exp_r);
    run(n, -1, 0, 0, res, lat);
    chk("after_busy_wr_result", res, exp_r);

    // Reset in the middle of an n=4 task
    pick(4);
    load(4);
    cfg_nwords = 3'd4; task_req = 1'b1;
    tick();
    task_req = 1'b0;
    repeat (19) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_valid", 64'(res_valid), 64'(0));
    chk("midrst_data", 64'(res_data), 64'(0));
    tick();
    rst_n = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (res_valid) vcnt++;
    end
    chk("midrst_no_valid", 64'(vcnt), 64'(0));
    mv = 64'hE5; m1v = 8'h13; xv = 64'h1B; yv = 64'h05;
    load(1);
    run(1, -1, 0, 0, res, lat);
    chk("postrst_result", res, 64'h05);
    chk("postrst_latency", 64'(lat), 64'(8));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
